// File: rtl/router_csr_pkg.sv
// Shared AHB-Lite encodings, data-phase state type and byte-lane helper for the
// router CSR bank.
`timescale 1ns/1ps
package router_csr_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        DATA_IDLE,
        DATA_OK,
        ERR1,
        ERR2
    } data_state_e;

    // Byte lanes touched by a transfer of size hsize at byte offset a within the word.
    function automatic logic [3:0] byte_mask(input logic [2:0] hsize, input logic [1:0] a);
        case (hsize)
            HSIZE_BYTE: byte_mask = 4'b0001 << a;
            HSIZE_HALF: byte_mask = a[1] ? 4'b1100 : 4'b0011;
            HSIZE_WORD: byte_mask = 4'b1111;
            default:    byte_mask = 4'b0000;
        endcase
    endfunction

endpackage

// File: rtl/router_ahb_slv_fsm.sv
// AHB-Lite slave front end: address-phase capture, access legality and the
// two-cycle ERROR response sequence.
`timescale 1ns/1ps
module router_ahb_slv_fsm
    import router_csr_pkg::*;
#(
    parameter int NUM_CFG  = 8,
    parameter int NUM_STA  = 8,
    parameter int CFG_BASE = 'h000,
    parameter int STA_BASE = 'h100
) (
    input  logic        i_hclk,
    input  logic        i_hreset,
    input  logic [11:0] i_haddr,
    input  logic        i_hwrite,
    input  logic        i_hsel,
    input  logic        i_htrans_act,
    input  logic [2:0]  i_hsize,
    input  logic        i_hreadyin,
    output logic        o_hready,
    output logic [1:0]  o_hresp,
    output logic        o_wr_en,
    output logic        o_rd_en,
    output logic [11:0] o_addr,
    output logic [3:0]  o_mask
);

    data_state_e state_q, state_d;
    logic [11:0] addr_q;
    logic        write_q;
    logic [2:0]  size_q;

    logic        accept;
    logic [31:0] off;
    logic        aligned, cfg_hit, sta_hit, legal;

    assign accept = i_hsel & i_htrans_act & i_hreadyin & o_hready;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        off     = {20'd0, i_haddr};
        aligned = 1'b1;
        case (i_hsize)
            HSIZE_HALF: aligned = ~i_haddr[0];
            HSIZE_WORD: aligned = (i_haddr[1:0] == 2'b00);
            default:    aligned = 1'b1;
        endcase
        cfg_hit = (off >= CFG_BASE) && (off < CFG_BASE + 4 * NUM_CFG);
        sta_hit = (off >= STA_BASE) && (off < STA_BASE + 4 * NUM_STA);
        legal   = (i_hsize <= HSIZE_WORD) && aligned && (cfg_hit || (sta_hit && !i_hwrite));
    end

    always_comb begin
        state_d = DATA_IDLE;
        if (accept) begin
            state_d = legal ? DATA_OK : ERR1;
        end else if (state_q == ERR1) begin
            state_d = ERR2;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            state_q <= DATA_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= i_haddr;
                write_q <= i_hwrite;
                size_q  <= i_hsize;
            end
        end
    end

    assign o_hready = (state_q != ERR1);
    assign o_hresp  = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
    assign o_wr_en  = (state_q == DATA_OK) && write_q;
    assign o_rd_en  = (state_q == DATA_OK) && !write_q;
    assign o_addr   = addr_q;
    assign o_mask   = byte_mask(size_q, addr_q[1:0]);

endmodule

// File: rtl/router_ahb_csr_bank.sv
// AHB-Lite CSR bank for the NoC router: read/write config words with commit
// pulses and read-only live status words.
`timescale 1ns/1ps
module router_ahb_csr_bank
    import router_csr_pkg::*;
#(
    parameter int          AWIDTH   = 32,
    parameter int          NUM_CFG  = 8,
    parameter int          NUM_STA  = 8,
    parameter int          CFG_BASE = 'h000,
    parameter int          STA_BASE = 'h100,
    parameter logic [31:0] CFG_RST  = 32'h0
) (
    input  logic                   i_hclk,
    input  logic                   i_hreset,
    input  logic [AWIDTH-1:0]      i_haddr,
    input  logic                   i_hwrite,
    input  logic                   i_hsel,
    input  logic [31:0]            i_hwdata,
    input  logic [1:0]             i_htrans,
    input  logic [2:0]             i_hsize,
    input  logic [2:0]             i_hburst,
    input  logic                   i_hreadyin,
    output logic                   o_hready,
    output logic [31:0]            o_hrdata,
    output logic [1:0]             o_hresp,
    output logic [NUM_CFG*32-1:0]  o_cfg,
    input  logic [NUM_STA*32-1:0]  i_sta,
    output logic [NUM_CFG-1:0]     o_cfg_wr,
    output logic                   o_changed
);

    logic        wr_en, rd_en;
    logic [11:0] addr;
    logic [3:0]  mask;

    logic [31:0]        cfg_q [NUM_CFG];
    logic [NUM_CFG-1:0] cfg_wr_q;
    logic [NUM_CFG-1:0] cfg_sel;
    logic [31:0]        wa;
    logic [31:0]        rd_data;

    // Burst type, the BUSY/IDLE distinction and the upper address bits carry no decode meaning.
    logic unused_bits;
    assign unused_bits = ^{i_hburst, i_htrans[0], i_haddr};

    router_ahb_slv_fsm #(
        .NUM_CFG  (NUM_CFG),
        .NUM_STA  (NUM_STA),
        .CFG_BASE (CFG_BASE),
        .STA_BASE (STA_BASE)
    ) u_fsm (
        .i_hclk       (i_hclk),
        .i_hreset     (i_hreset),
        .i_haddr      (i_haddr[11:0]),
        .i_hwrite     (i_hwrite),
        .i_hsel       (i_hsel),
        .i_htrans_act (i_htrans[1]),
        .i_hsize      (i_hsize),
        .i_hreadyin   (i_hreadyin),
        .o_hready     (o_hready),
        .o_hresp      (o_hresp),
        .o_wr_en      (wr_en),
        .o_rd_en      (rd_en),
        .o_addr       (addr),
        .o_mask       (mask)
    );

    assign wa = {20'd0, addr[11:2], 2'b00};

    always_comb begin
        cfg_sel = '0;
        for (int i = 0; i < NUM_CFG; i++) begin
            cfg_sel[i] = (wa == CFG_BASE + 4 * i);
        end
    end

    // Status words are sampled live, so a read reflects the core's value in the data phase.
    always_comb begin
        rd_data = '0;
        if (rd_en) begin
            for (int i = 0; i < NUM_CFG; i++) begin
                if (cfg_sel[i]) rd_data = cfg_q[i];
            end
            for (int j = 0; j < NUM_STA; j++) begin
                if (wa == STA_BASE + 4 * j) rd_data = i_sta[32*j +: 32];
            end
        end
    end

    // NOTE: the config array is reset because the router core consumes it right out of reset.
    always_ff @(posedge i_hclk) begin
        if (i_hreset) begin
            for (int i = 0; i < NUM_CFG; i++) cfg_q[i] <= CFG_RST;
            cfg_wr_q <= '0;
        end else begin
            cfg_wr_q <= '0;
            for (int i = 0; i < NUM_CFG; i++) begin
                if (wr_en && cfg_sel[i]) begin
                    cfg_wr_q[i] <= 1'b1;
                    for (int b = 0; b < 4; b++) begin
                        if (mask[b]) cfg_q[i][8*b +: 8] <= i_hwdata[8*b +: 8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_CFG; g++) begin : g_cfg_out
        assign o_cfg[32*g +: 32] = cfg_q[g];
    end

    assign o_hrdata  = rd_data;
    assign o_cfg_wr  = cfg_wr_q;
    assign o_changed = |cfg_wr_q;

endmodule
